critical_error_collector: RTL and testbench

CRITICAL_ERROR_COLLECTOR -- requirements
Module: critical_error_collector

---
 rtl/critical_error_collector.sv | 89 ++++++++
 tb/tb_critical_error_collector.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/critical_error_collector.sv
// critical_error_collector: latches critical-error sources, drains in-flight commits, reports once, then halts.
// Optional: define CRITERR_TIMESTAMP_EN to add a free-running cycle counter and the io_err_cycle output.
module critical_error_collector #(
    parameter int NUM_SRC      = 4,
    parameter int DRAIN_CYCLES = 8
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [NUM_SRC-1:0] io_src_err,
    input  logic [7:0]         io_coreid,
    output logic               io_out_enable,
    output logic               io_out_valid,
    output logic               io_out_criticalError,
    output logic [7:0]         io_out_coreid,
    output logic               io_halt,
`ifdef CRITERR_TIMESTAMP_EN
    output logic [31:0]        io_err_cycle,
`endif
    output logic [NUM_SRC-1:0] io_err_cause
);
    localparam logic [7:0] DRAIN_INIT = DRAIN_CYCLES[7:0];

    typedef enum logic [1:0] {IDLE, DRAIN, REPORT, HALTED} state_t;

    state_t             state;
    logic [NUM_SRC-1:0] mask;
    logic [7:0]         count;
    logic               report_q;
    logic               halt_q;

    // Collector FSM: capture sources, count down the drain window, pulse the report, then park.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state    <= IDLE;
            mask     <= '0;
            count    <= '0;
            report_q <= 1'b0;
            halt_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|io_src_err) begin
                        mask  <= io_src_err;
                        count <= DRAIN_INIT;
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    mask <= mask | io_src_err;
                    if (count == 8'd0) begin
                        state    <= REPORT;
                        report_q <= 1'b1;
                        halt_q   <= 1'b1;
                    end else begin
                        count <= count - 8'd1;
                    end
                end
                REPORT: begin
                    state    <= HALTED;
                    report_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef CRITERR_TIMESTAMP_EN
    logic [31:0] cycle_cnt;

    // Free-running timestamp; the value seen on the cycle of the first error is kept until reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cycle_cnt    <= '0;
            io_err_cycle <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (state == IDLE && |io_src_err)
                io_err_cycle <= cycle_cnt;
        end
    end
`endif

    assign io_out_enable        = report_q;
    assign io_out_valid         = report_q;
    assign io_out_criticalError = report_q;
    assign io_halt              = halt_q;
    assign io_out_coreid        = io_coreid;
    assign io_err_cause         = mask;
endmodule

// File: tb/tb_critical_error_collector.sv
// tb_critical_error_collector: randomized and directed checks of two instances (DRAIN_CYCLES 0 and 8) against a timeline model.
module tb_critical_error_collector;
    logic       clock   = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] src_err = '0;
    logic [7:0] coreid  = '0;
    logic [1:0] en, val, crit, halt;
    logic [7:0] ocid0, ocid1;
    logic [3:0] cause0, cause1;
    logic [15:0] act [2];
`ifdef CRITERR_TIMESTAMP_EN
    logic [31:0] ecyc0, ecyc1;
`endif

    int checks = 0;
    int errors = 0;
    int n = 0;
    int tf [2] = '{-1, -1};
    logic [3:0] mask [2] = '{4'h0, 4'h0};
    int dc [2] = '{0, 8};

    critical_error_collector #(.NUM_SRC(4), .DRAIN_CYCLES(0)) u_dut0 (
        .clock(clock), .reset_n(reset_n), .io_src_err(src_err), .io_coreid(coreid),
        .io_out_enable(en[0]), .io_out_valid(val[0]), .io_out_criticalError(crit[0]),
        .io_out_coreid(ocid0), .io_halt(halt[0]),
`ifdef CRITERR_TIMESTAMP_EN
        .io_err_cycle(ecyc0),
`endif
        .io_err_cause(cause0)
    );

    critical_error_collector #(.NUM_SRC(4), .DRAIN_CYCLES(8)) u_dut8 (
        .clock(clock), .reset_n(reset_n), .io_src_err(src_err), .io_coreid(coreid),
        .io_out_enable(en[1]), .io_out_valid(val[1]), .io_out_criticalError(crit[1]),
        .io_out_coreid(ocid1), .io_halt(halt[1]),
`ifdef CRITERR_TIMESTAMP_EN
        .io_err_cycle(ecyc1),
`endif
        .io_err_cause(cause1)
    );

    assign act[0] = {en[0], val[0], crit[0], halt[0], cause0, ocid0};
    assign act[1] = {en[1], val[1], crit[1], halt[1], cause1, ocid1};

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    // Drive one cycle of inputs, advance the timeline model, then step past the edge.
    task automatic cyc(input logic [3:0] e, input logic r);
        src_err = e;
        reset_n = r;
        for (int i = 0; i < 2; i++) begin
            if (!r) begin
                tf[i] = -1;
                mask[i] = 4'h0;
            end else if (tf[i] < 0) begin
                if (e != 4'h0) begin
                    tf[i] = n;
                    mask[i] = e;
                end
            end else if (n - tf[i] >= 1 && n - tf[i] <= dc[i] + 1) begin
                mask[i] = mask[i] | e;
            end
        end
        n = r ? n + 1 : 0;
        @(posedge clock);
        #1;
    endtask

    // Expected outputs: the report falls DRAIN+2 cycles after the first error, halt from then on.
    function automatic logic [15:0] exp_vec(input int i);
        int k;
        logic rep, hlt;
        k = tf[i] < 0 ? -1 : n - tf[i];
        rep = (k == dc[i] + 2);
        hlt = (k >= dc[i] + 2);
        return {rep, rep, rep, hlt, mask[i], coreid};
    endfunction

    task automatic test_reset();
        coreid = 8'h3c;
        cyc(4'hf, 1'b0);
        cyc(4'hf, 1'b0);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (act[i] !== exp_vec(i)) begin
                errors++;
                $display("FAIL reset d%0d got %h want %h", dc[i], act[i], exp_vec(i));
            end
        end
    endtask

    task automatic test_single(input logic [3:0] pat);
        coreid = 8'ha7;
        cyc(4'h0, 1'b0);
        cyc(pat, 1'b1);
        repeat (14) begin
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (act[i] !== exp_vec(i)) begin
                    errors++;
                    $display("FAIL single_%h d%0d cyc %0d got %h want %h", pat, dc[i], n, act[i], exp_vec(i));
                end
            end
            cyc(4'h0, 1'b1);
        end
    endtask

    task automatic test_last_drain();
        logic [3:0] seq [14];
        seq = '{4'h1, 4'h2, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h4, 4'h8, 4'h8, 4'h0, 4'h0};
        cyc(4'h0, 1'b0);
        for (int c = 0; c < 14; c++) begin
            cyc(seq[c], 1'b1);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (act[i] !== exp_vec(i)) begin
                    errors++;
                    $display("FAIL last_drain d%0d cyc %0d got %h want %h", dc[i], n, act[i], exp_vec(i));
                end
            end
        end
    endtask

    task automatic test_reset_abort();
        cyc(4'h0, 1'b0);
        cyc(4'h4, 1'b1);
        repeat (3) cyc(4'h0, 1'b1);
        cyc(4'h0, 1'b0);
        cyc(4'h0, 1'b1);
        cyc(4'h0, 1'b1);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (act[i] !== exp_vec(i)) begin
                errors++;
                $display("FAIL abort_idle d%0d got %h want %h", dc[i], act[i], exp_vec(i));
            end
        end
        cyc(4'h1, 1'b1);
        repeat (12) begin
            cyc(4'h0, 1'b1);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (act[i] !== exp_vec(i)) begin
                    errors++;
                    $display("FAIL abort_restart d%0d cyc %0d got %h want %h", dc[i], n, act[i], exp_vec(i));
                end
            end
        end
    endtask

    task automatic test_coreid();
        coreid = 8'h05;
        cyc(4'h0, 1'b0);
        cyc(4'h8, 1'b1);
        repeat (9) cyc(4'h0, 1'b1);
        checks++;
        if ({val[1], ocid1} !== 9'h105) begin
            errors++;
            $display("FAIL coreid_report got valid %b coreid %h want valid 1 coreid 05", val[1], ocid1);
        end
    endtask

    task automatic test_random();
        logic [3:0] e;
        logic r;
        repeat (60) begin
            coreid = 8'($urandom);
            cyc(4'h0, 1'b0);
            repeat ($urandom_range(0, 3)) cyc(4'h0, 1'b1);
            repeat (16) begin
                e = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
                r = ($urandom_range(0, 30) != 0);
                if ($urandom_range(0, 7) == 0) coreid = 8'($urandom);
                cyc(e, r);
                for (int i = 0; i < 2; i++) begin
                    checks++;
                    if (act[i] !== exp_vec(i)) begin
                        errors++;
                        $display("FAIL random d%0d cyc %0d got %h want %h", dc[i], n, act[i], exp_vec(i));
                    end
                end
            end
        end
    endtask

`ifdef CRITERR_TIMESTAMP_EN
    task automatic test_timestamp();
        cyc(4'h0, 1'b0);
        checks++;
        if ({ecyc0, ecyc1} !== 64'h0) begin
            errors++;
            $display("FAIL ts_reset got %h %h want 0", ecyc0, ecyc1);
        end
        repeat (100) cyc(4'h0, 1'b1);
        cyc(4'h2, 1'b1);
        repeat (20) begin
            cyc(4'($urandom), 1'b1);
            checks++;
            if (ecyc0 !== 32'(tf[0]) || ecyc1 !== 32'(tf[1])) begin
                errors++;
                $display("FAIL ts_capture got %0d %0d want %0d %0d", ecyc0, ecyc1, tf[0], tf[1]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single(4'b0010);
        test_single(4'b1001);
        test_last_drain();
        test_reset_abort();
        test_coreid();
        test_random();
`ifdef CRITERR_TIMESTAMP_EN
        test_timestamp();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
